// File: rtl/key_event_encoder.sv
// key_event_encoder
//   Turns six debounced key levels into a queue of key-event codes. Direction
//   keys (0..3) auto-repeat while they are held. Each key has its own pending
//   bit, so presses that arrive in the same cycle are all kept. The consumer
//   takes one event per valid/ready handshake.
//
// Ports
//   clk_50M    : system clock (single domain)
//   rst        : synchronous reset, active-high
//   key_level  : debounced levels, 1 = pressed
//                [0]left [1]right [2]up [3]down [4]confirm [5]quit
//   evt_valid  : the FIFO head holds an event
//   evt_ready  : the consumer pops the head when evt_valid & evt_ready
//   evt_code   : key index (0..5) of the head event
//   evt_repeat : the head event came from auto-repeat
//   fifo_level : number of queued events (0..FIFO_DEPTH)
//   overflow   : sticky flag, set when an event is coalesced into an
//                already-pending bit
//   ovf_clr    : clears overflow; a drop in the same cycle wins
module key_event_encoder #(
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 5_000_000,
    parameter int unsigned CNT_W         = 25,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                          clk_50M,
    input  logic                          rst,
    input  logic [5:0]                    key_level,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [2:0]                    evt_code,
    output logic                          evt_repeat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [5:0]       key_prev_q, key_prev_d;
    logic [5:0]       pend_q, pend_d;
    logic [5:0]       pend_rep_q, pend_rep_d;
    logic [1:0]       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mem_code_q [FIFO_DEPTH];
    logic [2:0]       mem_code_d [FIFO_DEPTH];
    logic             mem_rep_q  [FIFO_DEPTH];
    logic             mem_rep_d  [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [5:0] press;
    logic       tick;
    logic       pop;
    logic       full;
    logic       push;
    logic       found;
    logic [2:0] push_idx;
    logic       drop;
    logic       set_new;
    logic       popping_i;

    always_comb begin
        press      = key_level & ~key_prev_q;
        key_prev_d = key_level;

        // Auto-repeat timer. A fresh direction press always takes ownership,
        // even from a key that would have ticked in this cycle.
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        tick    = 1'b0;
        if (|press[3:0]) begin
            state_d = ST_DELAY;
            cnt_d   = '0;
            if (press[0])      owner_d = 2'd0;
            else if (press[1]) owner_d = 2'd1;
            else if (press[2]) owner_d = 2'd2;
            else               owner_d = 2'd3;
        end else if (state_q != ST_IDLE) begin
            if (!key_level[owner_q]) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (state_q == ST_DELAY) begin
                if (cnt_q == DELAY_LAST) begin
                    tick    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == PERIOD_LAST) begin
                    tick  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // FIFO handshake; a full FIFO still accepts a push when it pops.
        pop  = (count_q != '0) && evt_ready;
        full = (count_q == (AW+1)'(FIFO_DEPTH));

        found    = 1'b0;
        push_idx = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (pend_q[i] && !found) begin
                push_idx = 3'(i);
                found    = 1'b1;
            end
        end
        push = found && (!full || pop);

        // Pending bits. A new event on a bit that stays set this cycle is
        // merged into the older one, which keeps its repeat flag.
        pend_d     = pend_q;
        pend_rep_d = pend_rep_q;
        drop       = 1'b0;
        if (push) pend_d[push_idx] = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            set_new   = press[i] || (tick && (i < 4) && (owner_q == 2'(i)));
            popping_i = push && (push_idx == 3'(i));
            if (set_new) begin
                if (pend_q[i] && !popping_i) begin
                    drop = 1'b1;
                end else begin
                    pend_d[i]     = 1'b1;
                    pend_rep_d[i] = !press[i];
                end
            end
        end

        mem_code_d = mem_code_q;
        mem_rep_d  = mem_rep_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            mem_code_d[wr_ptr_q] = push_idx;
            mem_rep_d[wr_ptr_q]  = pend_rep_q[push_idx];
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

        overflow_d = ovf_clr ? 1'b0 : overflow_q;
        if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            key_prev_q <= '0;
            pend_q     <= '0;
            pend_rep_q <= '0;
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            cnt_q      <= '0;
            mem_code_q <= '{default: '0};
            mem_rep_q  <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            key_prev_q <= key_prev_d;
            pend_q     <= pend_d;
            pend_rep_q <= pend_rep_d;
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            mem_code_q <= mem_code_d;
            mem_rep_q  <= mem_rep_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign evt_valid  = (count_q != '0);
    assign evt_code   = mem_code_q[rd_ptr_q];
    assign evt_repeat = mem_rep_q[rd_ptr_q];
    assign fifo_level = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// tb_key_event_encoder
//   Directed bench for key_event_encoder with REPEAT_DELAY=8, REPEAT_PERIOD=4,
//   FIFO_DEPTH=4. Single-cycle scenarios are held in a vector table. Repeat
//   timing, owner hand-over and reset during repeat use hand-written loops.
//   Ports: none (top level).
module tb_key_event_encoder;

    logic       clk_50M;
    logic       rst;
    logic [5:0] key_level;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_code;
    logic       evt_repeat;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       ovf_clr;

    int n_cmp  = 0;
    int n_fail = 0;

    key_event_encoder #(
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4),
        .CNT_W        (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .key_level (key_level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_repeat(evt_repeat),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    typedef struct {
        logic       rst;
        logic [5:0] keys;
        logic       ready;
        logic       clr;
        logic       exp_valid;
        logic [2:0] exp_code;
        logic       exp_rep;
        logic [2:0] exp_level;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [5:0] k, input logic rd, input logic c,
                       input logic ev, input logic [2:0] ec, input logic er,
                       input logic [2:0] el, input logic eo);
        vec_t v;
        v.rst = r; v.keys = k; v.ready = rd; v.clr = c;
        v.exp_valid = ev; v.exp_code = ec; v.exp_rep = er;
        v.exp_level = el; v.exp_ovf = eo;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, advance one rising edge, then settle before sampling.
    task automatic step(input logic r, input logic [5:0] k, input logic rd, input logic c);
        rst = r; key_level = k; evt_ready = rd; ovf_clr = c;
        @(posedge clk_50M);
        #1;
    endtask

    initial begin
        rst = 1'b1; key_level = '0; evt_ready = 1'b0; ovf_clr = 1'b0;

        // Reset state
        step(1, 6'h00, 0, 0);
        step(1, 6'h00, 0, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_repeat", evt_repeat, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);

        // Scenario 1: one-cycle left press, consumer always ready
        add(0, 6'h01, 1, 0,  0, 0, 0, 0, 0);
        add(0, 6'h00, 1, 0,  1, 0, 0, 1, 0);
        add(0, 6'h00, 1, 0,  0, 0, 0, 0, 0);
        add(0, 6'h00, 1, 0,  0, 0, 0, 0, 0);
        add(0, 6'h00, 1, 0,  0, 0, 0, 0, 0);
        // Scenario 2: left+confirm together, consumer stalled then drains
        add(0, 6'h11, 0, 0,  0, 0, 0, 0, 0);
        add(0, 6'h00, 0, 0,  1, 0, 0, 1, 0);
        add(0, 6'h00, 0, 0,  1, 0, 0, 2, 0);
        add(0, 6'h00, 0, 0,  1, 0, 0, 2, 0);
        add(0, 6'h00, 1, 0,  1, 4, 0, 1, 0);
        add(0, 6'h00, 1, 0,  0, 0, 0, 0, 0);
        // Scenario 4: fill FIFO, confirm pending, quit twice -> overflow
        add(0, 6'h01, 0, 0,  0, 0, 0, 0, 0);
        add(0, 6'h02, 0, 0,  1, 0, 0, 1, 0);
        add(0, 6'h04, 0, 0,  1, 0, 0, 2, 0);
        add(0, 6'h08, 0, 0,  1, 0, 0, 3, 0);
        add(0, 6'h10, 0, 0,  1, 0, 0, 4, 0);
        add(0, 6'h20, 0, 0,  1, 0, 0, 4, 0);
        add(0, 6'h00, 0, 0,  1, 0, 0, 4, 0);
        add(0, 6'h20, 0, 0,  1, 0, 0, 4, 1);
        add(0, 6'h00, 1, 0,  1, 1, 0, 4, 1);
        add(0, 6'h00, 1, 0,  1, 2, 0, 4, 1);
        add(0, 6'h00, 1, 0,  1, 3, 0, 3, 1);
        add(0, 6'h00, 1, 0,  1, 4, 0, 2, 1);
        add(0, 6'h00, 1, 0,  1, 5, 0, 1, 1);
        add(0, 6'h00, 1, 0,  0, 0, 0, 0, 1);
        add(0, 6'h00, 1, 0,  0, 0, 0, 0, 1);
        add(0, 6'h00, 0, 1,  0, 0, 0, 0, 0);
        add(0, 6'h00, 0, 0,  0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].keys, tbl[i].ready, tbl[i].clr);
            chk($sformatf("vec%0d_valid", i), evt_valid, tbl[i].exp_valid);
            chk($sformatf("vec%0d_level", i), fifo_level, tbl[i].exp_level);
            chk($sformatf("vec%0d_ovf", i), overflow, tbl[i].exp_ovf);
            if (tbl[i].exp_valid) begin
                chk($sformatf("vec%0d_code", i), evt_code, tbl[i].exp_code);
                chk($sformatf("vec%0d_rep", i), evt_repeat, tbl[i].exp_rep);
            end
        end

        // Scenario 3: hold up 20 cycles; press event then repeats at +8,+12,+16
        for (int n = 0; n < 24; n++) begin
            logic ev;
            step(0, (n < 20) ? 6'h04 : 6'h00, 1, 0);
            ev = (n == 1) || (n == 9) || (n == 13) || (n == 17);
            chk($sformatf("hold_up%0d_valid", n), evt_valid, ev);
            chk($sformatf("hold_up%0d_level", n), fifo_level, ev ? 1 : 0);
            if (ev) begin
                chk($sformatf("hold_up%0d_code", n), evt_code, 2);
                chk($sformatf("hold_up%0d_rep", n), evt_repeat, (n != 1) ? 1 : 0);
            end
        end

        // Scenario 5: right repeating, down pressed -> down owns the timer
        for (int n = 0; n < 29; n++) begin
            logic [5:0] k;
            logic       ev;
            logic [2:0] ec;
            logic       er;
            k  = (n > 24) ? 6'h00 : ((n >= 10) ? 6'h0A : 6'h02);
            step(0, k, 1, 0);
            ev = 1'b0; ec = 3'd0; er = 1'b0;
            if (n == 1)  begin ev = 1'b1; ec = 3'd1; er = 1'b0; end
            if (n == 9)  begin ev = 1'b1; ec = 3'd1; er = 1'b1; end
            if (n == 11) begin ev = 1'b1; ec = 3'd3; er = 1'b0; end
            if (n == 19) begin ev = 1'b1; ec = 3'd3; er = 1'b1; end
            if (n == 23) begin ev = 1'b1; ec = 3'd3; er = 1'b1; end
            chk($sformatf("owner%0d_valid", n), evt_valid, ev);
            if (ev) begin
                chk($sformatf("owner%0d_code", n), evt_code, ec);
                chk($sformatf("owner%0d_rep", n), evt_repeat, er);
            end
        end

        // Scenario 6: reset in REPEAT with 3 events queued, key still held
        for (int n = 0; n < 15; n++) begin
            logic [2:0] el;
            step(0, 6'h01, 0, 0);
            el = (n >= 13) ? 3'd3 : (n >= 9) ? 3'd2 : (n >= 1) ? 3'd1 : 3'd0;
            chk($sformatf("prerst%0d_level", n), fifo_level, el);
        end
        step(1, 6'h01, 0, 0);
        chk("midrst_valid", evt_valid, 0);
        chk("midrst_level", fifo_level, 0);
        chk("midrst_ovf", overflow, 0);
        chk("midrst_code", evt_code, 0);
        chk("midrst_rep", evt_repeat, 0);
        step(0, 6'h01, 0, 0);
        chk("postrst1_valid", evt_valid, 0);
        step(0, 6'h01, 0, 0);
        chk("postrst2_valid", evt_valid, 1);
        chk("postrst2_code", evt_code, 0);
        chk("postrst2_rep", evt_repeat, 0);
        chk("postrst2_level", fifo_level, 1);
        step(0, 6'h00, 1, 0);
        chk("postrst3_valid", evt_valid, 0);
        chk("postrst3_level", fifo_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
